// File: rtl/fft_pkg.sv
// Shared FFT definitions: default butterfly widths/scaling and the signed
// complex twiddle type used to carry a sampled twiddle down the pipeline.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 27;  // signed input sample width per part
    localparam int unsigned FFT_TWID_WIDTH = 16;  // signed Q1.15 twiddle width
    localparam int unsigned FFT_SHIFT      = 15;  // right shift applied to twiddle products

    // Signed complex twiddle at the package default width.
    typedef struct packed {
        logic signed [FFT_TWID_WIDTH-1:0] re;
        logic signed [FFT_TWID_WIDTH-1:0] im;
    } twid_t;

endpackage

// File: rtl/cmul.sv
// cmul: two-stage pipelined complex multiplier p = a * b, or a * conj(b) when
// conj_b is set.
//   stage a: the four real partial products are registered
//   stage b: the partial products are combined into the complex result
// Both stages advance only when en is high; the result is full precision.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              pipeline advance enable
//   a_r, a_i        signed A_WIDTH multiplicand
//   b_r, b_i        signed B_WIDTH multiplier
//   conj_b          1 = multiply by conj(b)
//   p_r, p_i        signed A_WIDTH+B_WIDTH+1 product, two cycles after input
module cmul
    import fft_pkg::*;
#(
    parameter int unsigned A_WIDTH = FFT_DATA_WIDTH + 1,
    parameter int unsigned B_WIDTH = FFT_TWID_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic signed [A_WIDTH-1:0]         a_r,
    input  logic signed [A_WIDTH-1:0]         a_i,
    input  logic signed [B_WIDTH-1:0]         b_r,
    input  logic signed [B_WIDTH-1:0]         b_i,
    input  logic                              conj_b,
    output logic signed [A_WIDTH+B_WIDTH:0]   p_r,
    output logic signed [A_WIDTH+B_WIDTH:0]   p_i
);

    localparam int unsigned MW = A_WIDTH + B_WIDTH;  // partial product width
    localparam int unsigned SW = MW + 1;             // complex sum width

    logic signed [MW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic                 conj_q;

    // Stage a: partial products, operands sign-extended to full product width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
            conj_q <= 1'b0;
        end else if (en) begin
            rr_q   <= MW'(a_r) * MW'(b_r);
            ii_q   <= MW'(a_i) * MW'(b_i);
            ri_q   <= MW'(a_r) * MW'(b_i);
            ir_q   <= MW'(a_i) * MW'(b_r);
            conj_q <= conj_b;
        end
    end

    // Stage b: conj(b) flips the sign of every b_i term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= '0;
            p_i <= '0;
        end else if (en) begin
            if (conj_q) begin
                p_r <= SW'(rr_q) + SW'(ii_q);
                p_i <= SW'(ir_q) - SW'(ri_q);
            end else begin
                p_r <= SW'(rr_q) - SW'(ii_q);
                p_i <= SW'(ri_q) + SW'(ir_q);
            end
        end
    end

endmodule

// File: rtl/dif_butterfly.sv
// dif_butterfly: radix-2 decimation-in-frequency butterfly, 4-stage pipeline.
//   yp = xp + xq (sign-extended)
//   yq = ((xp - xq) * wn) >>> SHIFT, or * conj(wn) when inverse is set
// Stage 1 forms sum/difference, stages 2-3 run the complex multiplier (cmul),
// stage 4 scales and truncates. The whole pipeline advances together on
// enable = !out_valid || out_ready, so a stalled output freezes every stage.
// Configuration macro: DIF_BF_ROUND_EN adds 2^(SHIFT-1) to the yq sums before
// the shift (round half up); without it the shift truncates toward -inf.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   xp_r, xp_i, xq_r, xq_i       signed DATA_WIDTH input pair
//   wn_r, wn_i                   signed Q1.(TWID_WIDTH-1) twiddle
//   inverse                      1 = multiply by conj(wn)
//   in_valid, in_ready           input handshake
//   yp_r, yp_i, yq_r, yq_i       signed DATA_WIDTH+2 results
//   out_valid, out_ready         output handshake
module dif_butterfly
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned TWID_WIDTH = FFT_TWID_WIDTH,
    parameter int unsigned SHIFT      = FFT_SHIFT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [DATA_WIDTH-1:0]   xp_r,
    input  logic signed [DATA_WIDTH-1:0]   xp_i,
    input  logic signed [DATA_WIDTH-1:0]   xq_r,
    input  logic signed [DATA_WIDTH-1:0]   xq_i,
    input  logic signed [TWID_WIDTH-1:0]   wn_r,
    input  logic signed [TWID_WIDTH-1:0]   wn_i,
    input  logic                           inverse,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [DATA_WIDTH+1:0]   yp_r,
    output logic signed [DATA_WIDTH+1:0]   yp_i,
    output logic signed [DATA_WIDTH+1:0]   yq_r,
    output logic signed [DATA_WIDTH+1:0]   yq_i,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned S1W = DATA_WIDTH + 1;               // sum/difference width
    localparam int unsigned OW  = DATA_WIDTH + 2;               // output width
    localparam int unsigned PW  = DATA_WIDTH + TWID_WIDTH + 2;  // complex product width

    logic enable;

    assign enable   = !out_valid || out_ready;
    assign in_ready = enable;

    // ---------------------------------------------------------------- stage 1
    logic                  v1_q;
    logic                  inv1_q;
    twid_t                 w1_q;  // carried at the package twiddle width
    logic signed [S1W-1:0] s1_r_q, s1_i_q, d1_r_q, d1_i_q;
    logic signed [S1W-1:0] s1_r_d, s1_i_d, d1_r_d, d1_i_d;

    // One extra bit makes the sum and difference exact.
    always_comb begin
        s1_r_d = S1W'(xp_r) + S1W'(xq_r);
        s1_i_d = S1W'(xp_i) + S1W'(xq_i);
        d1_r_d = S1W'(xp_r) - S1W'(xq_r);
        d1_i_d = S1W'(xp_i) - S1W'(xq_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            inv1_q <= 1'b0;
            w1_q   <= '0;
            s1_r_q <= '0;
            s1_i_q <= '0;
            d1_r_q <= '0;
            d1_i_q <= '0;
        end else if (enable) begin
            v1_q    <= in_valid;
            inv1_q  <= inverse;
            w1_q.re <= wn_r;
            w1_q.im <= wn_i;
            s1_r_q  <= s1_r_d;
            s1_i_q  <= s1_i_d;
            d1_r_q  <= d1_r_d;
            d1_i_q  <= d1_i_d;
        end
    end

    // ----------------------------------------------------------- stages 2-3
    // -2^(TWID_WIDTH-1) passes through as an exact -1.0; the product width
    // already has room for it.
    logic signed [PW-1:0] p_r, p_i;

    cmul #(
        .A_WIDTH (S1W),
        .B_WIDTH (TWID_WIDTH)
    ) u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (enable),
        .a_r    (d1_r_q),
        .a_i    (d1_i_q),
        .b_r    (w1_q.re),
        .b_i    (w1_q.im),
        .conj_b (inv1_q),
        .p_r    (p_r),
        .p_i    (p_i)
    );

    // Valid bits and the sum path delayed alongside the multiplier.
    logic                  v2_q, v3_q;
    logic signed [S1W-1:0] s2_r_q, s2_i_q, s3_r_q, s3_i_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            s2_r_q <= '0;
            s2_i_q <= '0;
            s3_r_q <= '0;
            s3_i_q <= '0;
        end else if (enable) begin
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            s2_r_q <= s1_r_q;
            s2_i_q <= s1_i_q;
            s3_r_q <= s2_r_q;
            s3_i_q <= s2_i_q;
        end
    end

    // ---------------------------------------------------------------- stage 4
    // One guard bit so the rounding constant can never overflow the sum.
    logic signed [PW:0] acc_r, acc_i;

`ifdef DIF_BF_ROUND_EN
    localparam logic signed [PW:0] RND = (PW + 1)'(1) << (SHIFT - 1);
`endif

    always_comb begin
        acc_r = (PW + 1)'(p_r);
        acc_i = (PW + 1)'(p_i);
`ifdef DIF_BF_ROUND_EN
        acc_r = acc_r + RND;
        acc_i = acc_i + RND;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            yp_r      <= '0;
            yp_i      <= '0;
            yq_r      <= '0;
            yq_i      <= '0;
        end else if (enable) begin
            out_valid <= v3_q;
            yp_r      <= OW'(s3_r_q);
            yp_i      <= OW'(s3_i_q);
            // Arithmetic shift, then keep the low OW bits.
            yq_r      <= OW'(acc_r >>> SHIFT);
            yq_i      <= OW'(acc_i >>> SHIFT);
        end
    end

endmodule
